// File: rtl/myproject_div_pkg.sv
// Shared types and constants for the iterative 24s / 8ns divider.
package myproject_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  localparam int DEF_DIVIDEND_WIDTH = 24;
  localparam int DEF_DIVISOR_WIDTH  = 8;
  localparam int DEF_QUOTIENT_WIDTH = 16;

  // Largest and smallest values of a signed quotient of width w.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

  localparam int QMAX = sat_max(DEF_QUOTIENT_WIDTH);
  localparam int QMIN = sat_min(DEF_QUOTIENT_WIDTH);

endpackage

// File: rtl/myproject_div_step.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when the shifted remainder is large enough.
module myproject_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] part_rem,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] new_rem,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // The shifted remainder is below twice the divisor, so the result always fits WIDTH bits.
  always_comb begin
    shifted = {part_rem, next_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = (shifted >= {1'b0, divisor});
    new_rem = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/myproject_div_24s_8ns_16_seq.sv
// Iterative signed-dividend / unsigned-divisor divider with saturated quotient.
// One division in flight, valid/ready on both sides, clock enable freezes everything.
module myproject_div_24s_8ns_16_seq
  import myproject_div_pkg::*;
#(
  parameter int ID             = 1,
  parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH,
  parameter int QUOTIENT_WIDTH = DEF_QUOTIENT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ce,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [QUOTIENT_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH:0]    rem,
  output logic                      ovf,
  output logic                      dbz
);

  localparam int DW    = DIVIDEND_WIDTH;
  localparam int VW    = DIVISOR_WIDTH;
  localparam int QW    = QUOTIENT_WIDTH;
  localparam int CNT_W = $clog2(DW);
  localparam int Q_HI  = sat_max(QW);
  localparam int Q_LO  = sat_min(QW);

  localparam logic [DW:0]     POS_LIM = (DW+1)'(Q_HI);
  localparam logic [DW:0]     NEG_LIM = (DW+1)'(-Q_LO);
  localparam logic [QW-1:0]   SAT_HI  = QW'(Q_HI);
  localparam logic [QW-1:0]   SAT_LO  = QW'(Q_LO);

  // ID is an instance tag only; a negative tag is simply meaningless.
  if (ID < 0) begin : g_id_tag
  end

  div_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              neg;
  logic [DW-1:0]     dvd;
  logic [VW-1:0]     divisor;
  logic [VW-1:0]     prem;
  logic [DW:0]       qmag;

  logic [DW-1:0]     din0_mag;
  logic [VW-1:0]     step_rem;
  logic              step_bit;
  logic [QW-1:0]     fix_quot;
  logic [VW:0]       fix_rem;
  logic              fix_ovf;

  assign in_ready  = ce & (state == IDLE);
  assign out_valid = (state == DONE);

  // Magnitude of -2^(DW-1) still fits DW bits when read as unsigned.
  assign din0_mag = din0[DW-1] ? -din0 : din0;

  myproject_div_step #(
    .WIDTH(VW)
  ) u_step (
    .part_rem(prem),
    .next_bit(dvd[DW-1]),
    .divisor (divisor),
    .new_rem (step_rem),
    .q_bit   (step_bit)
  );

  // State register; reset wins over ce, ce gates every transition.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else if (ce) state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = (din1 == '0) ? DONE : CALC;
      CALC: if (cnt == '0) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Sign correction and saturation of the finished magnitude.
  always_comb begin
    fix_ovf  = 1'b0;
    fix_quot = '0;
    if (neg) begin
      if (qmag > NEG_LIM) begin
        fix_ovf  = 1'b1;
        fix_quot = SAT_LO;
      end else begin
        fix_quot = -qmag[QW-1:0];
      end
    end else begin
      if (qmag > POS_LIM) begin
        fix_ovf  = 1'b1;
        fix_quot = SAT_HI;
      end else begin
        fix_quot = qmag[QW-1:0];
      end
    end
    fix_rem = neg ? -{1'b0, prem} : {1'b0, prem};
  end

  // Datapath: operand capture, one restoring step per enabled cycle, result register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt     <= '0;
      neg     <= 1'b0;
      dvd     <= '0;
      divisor <= '0;
      prem    <= '0;
      qmag    <= '0;
      quot    <= '0;
      rem     <= '0;
      ovf     <= 1'b0;
      dbz     <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg     <= din0[DW-1];
            dvd     <= din0_mag;
            divisor <= din1;
            prem    <= '0;
            qmag    <= '0;
            cnt     <= CNT_W'(DW - 1);
            if (din1 == '0) begin
              quot <= din0[DW-1] ? SAT_LO : SAT_HI;
              rem  <= '0;
              ovf  <= 1'b0;
              dbz  <= 1'b1;
            end
          end
        end
        CALC: begin
          prem <= step_rem;
          dvd  <= {dvd[DW-2:0], 1'b0};
          qmag <= {qmag[DW-1:0], step_bit};
          cnt  <= cnt - CNT_W'(1);
        end
        FIX: begin
          quot <= fix_quot;
          rem  <= fix_rem;
          ovf  <= fix_ovf;
          dbz  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_myproject_div_24s_8ns_16_seq.sv
// Directed self-checking bench for the iterative divider.
module tb_myproject_div_24s_8ns_16_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] din0;
  logic [7:0]  din1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quot;
  logic [8:0]  rem;
  logic        ovf;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  myproject_div_24s_8ns_16_seq #(
    .ID(1), .DIVIDEND_WIDTH(24), .DIVISOR_WIDTH(8), .QUOTIENT_WIDTH(16)
  ) dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .rem(rem), .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic signed [31:0] actual,
                             input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic waitResult(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [23:0] a, input logic [7:0] b, output int lat);
    din0 = a; din1 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitResult(lat);
  endtask

  task automatic consumeResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic runDivision(input string tag, input int a, input int b,
                             input int eq, input int er, input int eovf,
                             input int edbz, input int elat);
    int lat;
    applyStimulus(a[23:0], b[7:0], lat);
    checkOutput({tag, "_lat"},   lat, elat);
    checkOutput({tag, "_quot"},  $signed(quot), eq);
    checkOutput({tag, "_rem"},   $signed(rem), er);
    checkOutput({tag, "_ovf"},   ovf, eovf);
    checkOutput({tag, "_dbz"},   dbz, edbz);
    consumeResult();
    checkOutput({tag, "_drain"}, out_valid, 0);
  endtask

  initial begin
    int lat;
    logic stable;
    logic seen;

    reset = 1'b0; ce = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    din0 = '0; din1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_quot", quot, 0);
    checkOutput("rst_rem", rem, 0);
    checkOutput("rst_flags", {ovf, dbz}, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    reset = 1'b1;
    ce = 1'b0; #1;
    checkOutput("ce_low_in_ready", in_ready, 0);
    ce = 1'b1;
    @(posedge clk); #1;

    runDivision("pos",       1000,     7,    142,    6, 0, 0, 25);
    runDivision("neg",      -1000,     7,   -142,   -6, 0, 0, 25);
    runDivision("big_div",   1000,   255,      3,  235, 0, 0, 25);
    runDivision("neg_sat", -8388608,  255, -32768, -128, 1, 0, 25);
    runDivision("pos_sat",  8388607,    1,  32767,    0, 1, 0, 25);
    runDivision("edge_lo",   -32768,    1, -32768,    0, 0, 0, 25);
    runDivision("edge_hi",    32768,    1,  32767,    0, 1, 0, 25);
    runDivision("dbz_pos",      500,    0,  32767,    0, 0, 1, 0);
    runDivision("dbz_neg",     -500,    0, -32768,    0, 0, 1, 0);

    // Backpressure: result held in DONE while out_ready is low.
    applyStimulus(24'd1000, 8'd7, lat);
    checkOutput("bp_lat", lat, 25);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || quot !== 16'd142 || rem !== 9'd6) stable = 1'b0;
    end
    checkOutput("bp_stable", stable, 1);
    ce = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_ce_hold", out_valid, 1);
    ce = 1'b1;
    din0 = -24'sd1000; din1 = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_release_valid", out_valid, 0);
    checkOutput("bp_release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    waitResult(lat);
    checkOutput("bp_next_lat", lat, 25);
    checkOutput("bp_next_quot", $signed(quot), -142);
    consumeResult();

    // Clock enable toggled every other cycle: twice the latency, same answer.
    din0 = 24'd1000; din1 = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ce = 1'b0;
    lat = 0;
    while (!out_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      ce = ~ce;
    end
    ce = 1'b1;
    checkOutput("ce_lat", lat, 50);
    checkOutput("ce_quot", $signed(quot), 142);
    checkOutput("ce_rem", $signed(rem), 6);
    consumeResult();

    // Reset in the middle of CALC aborts the division without a result.
    din0 = 24'd1000; din1 = 8'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("abort_valid", seen, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    checkOutput("abort_quot", quot, 0);
    runDivision("after_rst", -7, 7, -1, 0, 0, 0, 25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
